// File: rtl/secure_reg_pkg.sv
// Shared types and constants for the secure register access front-end.
package secure_reg_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_TID_WIDTH  = 2;
  localparam int unsigned PRIV_TID       = 0;

  typedef struct packed {
    logic                      wr;
    logic [DEF_TID_WIDTH-1:0]  tid;
    logic [DEF_DATA_WIDTH-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return 8'hFF;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/secure_req_fifo.sv
// Synchronous request FIFO; a pop frees a slot for a push in the same cycle.
module secure_req_fifo
  import secure_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push_s, do_pop_s;

  assign full      = (cnt_q == (AW+1)'(DEPTH));
  assign empty     = (cnt_q == (AW+1)'(0));
  assign dout      = mem_q[rd_ptr_q];
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      cnt_q    <= {(AW+1){1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/secure_reg_access_ctrl.sv
// Thread-tagged front-end for the secure register: buffers requests, lets only
// the privileged thread reach the register, and answers every request in order.
module secure_reg_access_ctrl
  import secure_reg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned TID_WIDTH  = DEF_TID_WIDTH,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [TID_WIDTH-1:0]  req_tid,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [TID_WIDTH-1:0]  rsp_tid,
  output logic [DATA_WIDTH-1:0] reg_data_in,
  output logic                  reg_wr_en,
  output logic                  reg_access_en,
  output logic [TID_WIDTH-1:0]  reg_thread_id,
  input  logic [DATA_WIDTH-1:0] reg_data_out,
  output logic                  viol_sticky,
  output logic [7:0]            viol_count
);

  typedef struct packed {
    logic                  wr;
    logic [TID_WIDTH-1:0]  tid;
    logic [DATA_WIDTH-1:0] wdata;
  } cur_req_t;

  localparam int unsigned          RW   = $bits(cur_req_t);
  localparam logic [TID_WIDTH-1:0] PRIV = TID_WIDTH'(PRIV_TID);

  logic                  fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;
  logic [RW-1:0]         fifo_dout_s;
  cur_req_t              head_s, push_word_s;
  logic                  head_perm_s;

  state_e                state_q, state_d;
  cur_req_t              cur_q, cur_d;
  logic                  perm_q, perm_d;
  logic                  reg_access_en_q, reg_access_en_d;
  logic                  reg_wr_en_q, reg_wr_en_d;
  logic [DATA_WIDTH-1:0] reg_data_in_q, reg_data_in_d;
  logic [TID_WIDTH-1:0]  reg_thread_id_q, reg_thread_id_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [TID_WIDTH-1:0]  rsp_tid_q, rsp_tid_d;
  logic                  viol_sticky_q, viol_sticky_d;
  logic [7:0]            viol_count_q, viol_count_d;

  assign req_ready   = ~fifo_full_s;
  assign fifo_push_s = req_valid & ~fifo_full_s;
  assign push_word_s = '{wr: req_wr, tid: req_tid, wdata: req_wdata};
  assign head_s      = cur_req_t'(fifo_dout_s);

  secure_req_fifo #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push_s),
    .din   (push_word_s),
    .pop   (fifo_pop_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Policy check: anything not provably the privileged thread (incl. X) is denied
  always_comb begin
    if (head_s.tid == PRIV) begin
      head_perm_s = 1'b1;
    end else begin
      head_perm_s = 1'b0;
    end
  end

  // Request sequencer: pop, issue, capture, respond
  always_comb begin
    state_d         = state_q;
    cur_d           = cur_q;
    perm_d          = perm_q;
    reg_access_en_d = 1'b0;
    reg_wr_en_d     = 1'b0;
    reg_data_in_d   = {DATA_WIDTH{1'b0}};
    reg_thread_id_d = {TID_WIDTH{1'b0}};
    rsp_valid_d     = rsp_valid_q;
    rsp_rdata_d     = rsp_rdata_q;
    rsp_err_d       = rsp_err_q;
    rsp_tid_d       = rsp_tid_q;
    viol_sticky_d   = viol_sticky_q;
    viol_count_d    = viol_count_q;
    fifo_pop_s      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          fifo_pop_s = 1'b1;
          cur_d      = head_s;
          perm_d     = head_perm_s;
          state_d    = ST_ISSUE;
          // Strobes are registered, so they are set up here to be live during ISSUE
          if (head_perm_s) begin
            reg_access_en_d = 1'b1;
            reg_wr_en_d     = head_s.wr;
            reg_data_in_d   = head_s.wdata;
            reg_thread_id_d = head_s.tid;
          end else begin
            reg_access_en_d = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (!perm_q) begin
          viol_count_d  = sat_inc8(viol_count_q);
          viol_sticky_d = 1'b1;
        end else begin
          viol_count_d = viol_count_q;
        end
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (perm_q && !cur_q.wr) begin
          rsp_rdata_d = reg_data_out;
        end else begin
          rsp_rdata_d = {DATA_WIDTH{1'b0}};
        end
        rsp_err_d   = ~perm_q;
        rsp_tid_d   = cur_q.tid;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // Sequencer, strobe and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      cur_q           <= '{wr: 1'b0, tid: {TID_WIDTH{1'b0}}, wdata: {DATA_WIDTH{1'b0}}};
      perm_q          <= 1'b0;
      reg_access_en_q <= 1'b0;
      reg_wr_en_q     <= 1'b0;
      reg_data_in_q   <= {DATA_WIDTH{1'b0}};
      reg_thread_id_q <= {TID_WIDTH{1'b0}};
      rsp_valid_q     <= 1'b0;
      rsp_rdata_q     <= {DATA_WIDTH{1'b0}};
      rsp_err_q       <= 1'b0;
      rsp_tid_q       <= {TID_WIDTH{1'b0}};
      viol_sticky_q   <= 1'b0;
      viol_count_q    <= 8'd0;
    end else begin
      state_q         <= state_d;
      cur_q           <= cur_d;
      perm_q          <= perm_d;
      reg_access_en_q <= reg_access_en_d;
      reg_wr_en_q     <= reg_wr_en_d;
      reg_data_in_q   <= reg_data_in_d;
      reg_thread_id_q <= reg_thread_id_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_rdata_q     <= rsp_rdata_d;
      rsp_err_q       <= rsp_err_d;
      rsp_tid_q       <= rsp_tid_d;
      viol_sticky_q   <= viol_sticky_d;
      viol_count_q    <= viol_count_d;
    end
  end

  assign reg_access_en = reg_access_en_q;
  assign reg_wr_en     = reg_wr_en_q;
  assign reg_data_in   = reg_data_in_q;
  assign reg_thread_id = reg_thread_id_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_tid       = rsp_tid_q;
  assign viol_sticky   = viol_sticky_q;
  assign viol_count    = viol_count_q;

endmodule
